// File: rtl/chess_pkg.sv
// Shared chessboard types, geometry constants and pipeline bundles
// for the per-pixel sprite fetch front end.
package chess_pkg;

    typedef enum logic [3:0] {
        EMPTY  = 4'd0,
        PAWN   = 4'd1,
        KNIGHT = 4'd2,
        BISHOP = 4'd3,
        ROOK   = 4'd4,
        QUEEN  = 4'd5,
        KING   = 4'd6
    } piece_t;

    localparam logic [3:0] BLACK = 4'h8;

    localparam int BOARD_X0 = 192;
    localparam int BOARD_Y0 = 112;
    localparam int SQ_LOG2  = 5;
    localparam int BOARD_PX = 1 << (SQ_LOG2 + 3);

    localparam logic [3:0] TRANSP_INDEX = 4'd1;

    typedef struct packed {
        logic               valid;
        logic               inb;
        logic [2:0]         row;
        logic [2:0]         col;
        logic [SQ_LOG2-1:0] sx;
        logic [SQ_LOG2-1:0] sy;
    } s0_t;

    typedef struct packed {
        logic               valid;
        logic               inb;
        logic               dark;
        logic               hl;
        logic [3:0]         piece;
        logic [SQ_LOG2-1:0] sx;
        logic [SQ_LOG2-1:0] sy;
    } s1_t;

    typedef struct packed {
        logic       valid;
        logic       inb;
        logic       dark;
        logic       hl;
        logic [3:0] piece;
        logic [3:0] pal;
        logic       opaque;
    } out_t;

    function automatic logic piece_present(input logic [3:0] p);
        return p != EMPTY;
    endfunction

endpackage

// File: rtl/board_locator.sv
// Maps a screen coordinate onto the board: in-board test, square
// row/col and the pixel offset inside the square.
module board_locator
    import chess_pkg::*;
(
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    output logic               inb,
    output logic [2:0]         row,
    output logic [2:0]         col,
    output logic [SQ_LOG2-1:0] sx,
    output logic [SQ_LOG2-1:0] sy
);

    localparam int RW = SQ_LOG2 + 3;

    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic          inb_x;
    logic          inb_y;

    // Only the low board-width bits of the wrapped offset matter.
    always_comb begin
        rx    = RW'(draw_x - 10'(BOARD_X0));
        ry    = RW'(draw_y - 10'(BOARD_Y0));
        inb_x = (draw_x >= 10'(BOARD_X0)) &&
                (draw_x <  10'(BOARD_X0 + BOARD_PX));
        inb_y = (draw_y >= 10'(BOARD_Y0)) &&
                (draw_y <  10'(BOARD_Y0 + BOARD_PX));
        inb   = inb_x && inb_y;
        col   = rx[RW-1:SQ_LOG2];
        row   = ry[RW-1:SQ_LOG2];
        sx    = rx[SQ_LOG2-1:0];
        sy    = ry[SQ_LOG2-1:0];
    end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Three-stage pixel pipeline: locate square, read board RAM, read
// sprite ROM; outputs aligned to the pixel for the colour mux.
module sprite_pixel_fetch
    import chess_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    input  logic [6:0]  sel_sq,
    output logic [5:0]  sq_addr,
    input  logic [3:0]  sq_piece,
    output logic [13:0] spr_addr,
    input  logic [3:0]  spr_index,
    output logic        out_valid,
    output logic        in_board,
    output logic        square_dark,
    output logic        highlight,
    output logic [3:0]  piece_code,
    output logic [3:0]  pal_index,
    output logic        opaque
);

    s0_t  s0_d, s0_q;
    s1_t  s1_d, s1_q;
    out_t out_d, out_q;

    logic               lo_inb;
    logic [2:0]         lo_row;
    logic [2:0]         lo_col;
    logic [SQ_LOG2-1:0] lo_sx;
    logic [SQ_LOG2-1:0] lo_sy;

    board_locator u_loc (
        .draw_x (draw_x),
        .draw_y (draw_y),
        .inb    (lo_inb),
        .row    (lo_row),
        .col    (lo_col),
        .sx     (lo_sx),
        .sy     (lo_sy)
    );

    always_comb begin
        s0_d  = s0_q;
        s1_d  = s1_q;
        out_d = out_q;
        if (pix_en) begin
            s0_d.valid = 1'b1;
            s0_d.inb   = lo_inb;
            s0_d.row   = lo_row;
            s0_d.col   = lo_col;
            s0_d.sx    = lo_sx;
            s0_d.sy    = lo_sy;

            s1_d.valid = s0_q.valid;
            s1_d.inb   = s0_q.inb;
            s1_d.piece = s0_q.inb ? sq_piece : 4'(EMPTY);
            s1_d.dark  = s0_q.row[0] ^ s0_q.col[0];
            // Wrapped off-board coordinates must never light the cursor.
            s1_d.hl    = s0_q.inb && sel_sq[6] &&
                         (sel_sq[5:0] == {s0_q.row, s0_q.col});
            s1_d.sx    = s0_q.sx;
            s1_d.sy    = s0_q.sy;

            out_d.valid  = s1_q.valid;
            out_d.inb    = s1_q.inb;
            out_d.dark   = s1_q.dark;
            out_d.hl     = s1_q.hl;
            out_d.piece  = s1_q.piece;
            out_d.pal    = piece_present(s1_q.piece) ? spr_index : 4'd0;
            out_d.opaque = piece_present(s1_q.piece) &&
                           (spr_index != TRANSP_INDEX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q  <= '0;
            s1_q  <= '0;
            out_q <= '0;
        end else begin
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            out_q <= out_d;
        end
    end

    assign sq_addr     = {s0_q.row, s0_q.col};
    assign spr_addr    = {s1_q.piece, s1_q.sy, s1_q.sx};
    assign out_valid   = out_q.valid;
    assign in_board    = out_q.inb;
    assign square_dark = out_q.dark;
    assign highlight   = out_q.hl;
    assign piece_code  = out_q.piece;
    assign pal_index   = out_q.pal;
    assign opaque      = out_q.opaque;

endmodule
